// File: rtl/ysyx_040066_cache_axi_bridge_if.sv
// AXI4 master-side bus bundle between the cache bridge and the interconnect.
// The bridge uses the master modport; the interconnect/slave model uses slave.
interface ysyx_040066_cache_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [3:0]          arid;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;

  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;

  logic [3:0]          awid;
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;

  modport master (
    output arid, arvalid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rlast, output rready,
    output awid, awvalid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, output bready
  );

  modport slave (
    input  arid, arvalid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast, input rready,
    input  awid, awvalid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, input bready
  );
endinterface

// File: rtl/ysyx_040066_cache_axi_bridge.sv
// Cache line refill / write-back to AXI4 bridge: 8-beat INCR bursts for cached
// lines, single beats for uncached. Optional counters under CACHE_AXI_PERF_EN.
module ysyx_040066_cache_axi_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int LINE_LEN = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                rd_req_i,
  input  logic                wr_req_i,
  input  logic [LINE_LEN-1:0] wr_data_i,
  input  logic [7:0]          wr_strb_i,
  output logic                rd_ready_o,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_last_o,
  output logic                rd_error_o,
  output logic                wr_ready_o,
  output logic                wr_error_o,
  ysyx_040066_cache_axi_bridge_if.master axi
`ifdef CACHE_AXI_PERF_EN
  ,
  output logic [31:0]         perf_rd_bursts_o,
  output logic [31:0]         perf_wr_bursts_o,
  output logic [31:0]         perf_stall_cycles_o
`endif
);

  localparam logic [7:0] BURST_LEN = 8'(LINE_LEN / DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_LEN-1:0] line_q, line_d;
  logic [7:0]          strb_q, strb_d;
  logic                unc_q, unc_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic       arvalid_s, rready_s, awvalid_s, wvalid_s, bready_s, wlast_s;
  logic       ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  logic [7:0] len_s;
  logic [8:0] beat_idx_s;
  logic       unused_resp_s;

  assign len_s      = unc_q ? 8'd0 : BURST_LEN;
  assign arvalid_s  = (state_q == S_AR);
  assign rready_s   = (state_q == S_R);
  // Each channel's valid drops once its own handshake is done; the other may still be pending.
  assign awvalid_s  = (state_q == S_WR) && !aw_done_q;
  assign wvalid_s   = (state_q == S_WR) && !w_done_q;
  assign bready_s   = (state_q == S_B);
  assign wlast_s    = (cnt_q == len_s[2:0]);
  assign beat_idx_s = {cnt_q, 6'd0};

  assign ar_hs_s = arvalid_s & axi.arready;
  assign r_hs_s  = rready_s  & axi.rvalid;
  assign aw_hs_s = awvalid_s & axi.awready;
  assign w_hs_s  = wvalid_s  & axi.wready;
  assign b_hs_s  = bready_s  & axi.bvalid;

  assign axi.arid    = 4'd0;
  assign axi.arvalid = arvalid_s;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_s;
  assign axi.arsize  = 3'd3;
  assign axi.arburst = 2'b01;
  assign axi.rready  = rready_s;
  assign axi.awid    = 4'd0;
  assign axi.awvalid = awvalid_s;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_s;
  assign axi.awsize  = 3'd3;
  assign axi.awburst = 2'b01;
  assign axi.wvalid  = wvalid_s;
  assign axi.wdata   = line_q[beat_idx_s +: DATA_W];
  assign axi.wstrb   = unc_q ? strb_q : 8'hFF;
  assign axi.wlast   = wlast_s;
  assign axi.bready  = bready_s;

  assign rd_ready_o = r_hs_s;
  assign rd_data_o  = axi.rdata;
  assign rd_last_o  = axi.rlast;
  assign rd_error_o = r_hs_s & axi.rresp[1];
  assign wr_ready_o = b_hs_s;
  assign wr_error_o = b_hs_s & axi.bresp[1];

  assign unused_resp_s = axi.rresp[0] ^ axi.bresp[0];

  // Next-state logic for the transaction FSM and its latched request.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    line_d    = line_q;
    strb_d    = strb_q;
    unc_d     = unc_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = 3'd0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (wr_req_i || rd_req_i) begin
          addr_d  = addr_i;
          line_d  = wr_data_i;
          strb_d  = wr_strb_i;
          unc_d   = ~addr_i[ADDR_W-1];
          state_d = wr_req_i ? S_WR : S_AR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (axi.arready) begin
          state_d = S_R;
        end else begin
          state_d = S_AR;
        end
      end
      S_R: begin
        if (axi.rvalid) begin
          cnt_d   = cnt_q + 3'd1;
          state_d = axi.rlast ? S_IDLE : S_R;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      S_WR: begin
        if (aw_hs_s) begin
          aw_done_d = 1'b1;
        end else begin
          aw_done_d = aw_done_q;
        end
        if (w_hs_s && wlast_s) begin
          w_done_d = 1'b1;
          cnt_d    = 3'd0;
        end else if (w_hs_s) begin
          cnt_d    = cnt_q + 3'd1;
        end else begin
          cnt_d    = cnt_q;
        end
        if ((aw_done_q || aw_hs_s) && (w_done_q || (w_hs_s && wlast_s))) begin
          state_d = S_B;
        end else begin
          state_d = S_WR;
        end
      end
      S_B: begin
        if (axi.bvalid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_B;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      line_q    <= '0;
      strb_q    <= 8'd0;
      unc_q     <= 1'b0;
      cnt_q     <= 3'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      strb_q    <= strb_d;
      unc_q     <= unc_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef CACHE_AXI_PERF_EN
  logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;
  logic        any_hs_s;

  assign any_hs_s = ar_hs_s | r_hs_s | aw_hs_s | w_hs_s | b_hs_s;

  // Burst and stall counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_q    <= 32'd0;
      perf_wr_q    <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (r_hs_s && axi.rlast) begin
        perf_rd_q <= perf_rd_q + 32'd1;
      end
      if (b_hs_s) begin
        perf_wr_q <= perf_wr_q + 32'd1;
      end
      if ((state_q != S_IDLE) && !any_hs_s) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_rd_bursts_o    = perf_rd_q;
  assign perf_wr_bursts_o    = perf_wr_q;
  assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_040066_cache_axi_bridge.sv
// Directed bench for the cache/AXI bridge: tasks play cache and AXI slave,
// a negedge monitor checks every handshake against per-channel queues.
module tb_ysyx_040066_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr;
  logic         rd_req, wr_req;
  logic [511:0] wr_data;
  logic [7:0]   wr_strb;
  logic         rd_ready, rd_last, rd_error, wr_ready, wr_error;
  logic [63:0]  rd_data;
`ifdef CACHE_AXI_PERF_EN
  logic [31:0]  perf_rd, perf_wr, perf_stall;
`endif

  ysyx_040066_cache_axi_bridge_if bus ();

  ysyx_040066_cache_axi_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr),
    .rd_req_i   (rd_req),
    .wr_req_i   (wr_req),
    .wr_data_i  (wr_data),
    .wr_strb_i  (wr_strb),
    .rd_ready_o (rd_ready),
    .rd_data_o  (rd_data),
    .rd_last_o  (rd_last),
    .rd_error_o (rd_error),
    .wr_ready_o (wr_ready),
    .wr_error_o (wr_error),
    .axi        (bus)
`ifdef CACHE_AXI_PERF_EN
    ,
    .perf_rd_bursts_o    (perf_rd),
    .perf_wr_bursts_o    (perf_wr),
    .perf_stall_cycles_o (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_ar[$];
  logic [39:0] exp_aw[$];
  logic [72:0] exp_w[$];
  logic [65:0] exp_rd[$];
  logic        exp_wr[$];

  logic [39:0] m_ar, m_aw;
  logic [72:0] m_w;
  logic [65:0] m_rd;
  logic        m_wr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one queue per channel so AW/W ordering may differ.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.arvalid && bus.arready) begin
        if (exp_ar.size() == 0) chk("ar_extra", 64'd1, 64'd0);
        else begin
          m_ar = exp_ar.pop_front();
          chk("araddr",  64'(bus.araddr),  64'(m_ar[39:8]));
          chk("arlen",   64'(bus.arlen),   64'(m_ar[7:0]));
          chk("arsize",  64'(bus.arsize),  64'd3);
          chk("arburst", 64'(bus.arburst), 64'd1);
          chk("arid",    64'(bus.arid),    64'd0);
        end
      end
      if (bus.awvalid && bus.awready) begin
        if (exp_aw.size() == 0) chk("aw_extra", 64'd1, 64'd0);
        else begin
          m_aw = exp_aw.pop_front();
          chk("awaddr",  64'(bus.awaddr),  64'(m_aw[39:8]));
          chk("awlen",   64'(bus.awlen),   64'(m_aw[7:0]));
          chk("awsize",  64'(bus.awsize),  64'd3);
          chk("awburst", 64'(bus.awburst), 64'd1);
        end
      end
      if (bus.wvalid && bus.wready) begin
        if (exp_w.size() == 0) chk("w_extra", 64'd1, 64'd0);
        else begin
          m_w = exp_w.pop_front();
          chk("wdata", bus.wdata,        m_w[63:0]);
          chk("wstrb", 64'(bus.wstrb),   64'(m_w[71:64]));
          chk("wlast", 64'(bus.wlast),   64'(m_w[72]));
        end
      end
      if (rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_extra", 64'd1, 64'd0);
        else begin
          m_rd = exp_rd.pop_front();
          chk("rd_data",  rd_data,         m_rd[63:0]);
          chk("rd_last",  64'(rd_last),    64'(m_rd[64]));
          chk("rd_error", 64'(rd_error),   64'(m_rd[65]));
        end
      end
      if (wr_ready) begin
        if (exp_wr.size() == 0) chk("wr_extra", 64'd1, 64'd0);
        else begin
          m_wr = exp_wr.pop_front();
          chk("wr_error", 64'(wr_error), 64'(m_wr));
        end
      end
    end
  end

  task automatic slave_idle();
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 64'd0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
  endtask

  function automatic logic [63:0] rbeat(input logic [63:0] seed, input int i);
    return seed + 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  // Cache read request plus slave R responses; abort_beat < nb pulls rst_n mid-burst.
  task automatic do_read(input logic [31:0] a, input int nb, input int err_beat,
                         input int abort_beat, input logic [63:0] seed);
    int n;
    exp_ar.push_back({a, (nb == 1) ? 8'd0 : 8'd7});
    for (int i = 0; i < nb && i < abort_beat; i++)
      exp_rd.push_back({(i == err_beat), (i == nb - 1), rbeat(seed, i)});
    addr = a; rd_req = 1'b1;
    tick();
    n = 0;
    while (!bus.arvalid && n < 20) begin tick(); n++; end
    if (!bus.arvalid) begin
      chk("ar_timeout", 64'd0, 64'd1);
      rd_req = 1'b0;
      return;
    end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = rbeat(seed, i);
      bus.rlast  = (i == nb - 1);
      bus.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      if (i == abort_beat) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rd_ready", 64'(rd_ready),    64'd0);
        chk("rst_rready",   64'(bus.rready),  64'd0);
        chk("rst_arvalid",  64'(bus.arvalid), 64'd0);
        chk("rst_awvalid",  64'(bus.awvalid), 64'd0);
        chk("rst_wvalid",   64'(bus.wvalid),  64'd0);
        chk("rst_wr_ready", 64'(wr_ready),    64'd0);
        slave_idle();
        rd_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      tick();
    end
    rd_req = 1'b0;
    slave_idle();
    chk("r_exit_rready", 64'(bus.rready), 64'd0);
  endtask

  // Cache write request plus slave AW/W/B; aw_delay > 0 holds awready until after W.
  task automatic do_write(input logic [31:0] a, input logic [511:0] line, input logic [7:0] strb,
                          input int nb, input int aw_delay, input logic b_err);
    exp_aw.push_back({a, (nb == 1) ? 8'd0 : 8'd7});
    for (int i = 0; i < nb; i++)
      exp_w.push_back({(i == nb - 1), (nb == 1) ? strb : 8'hFF, line[i*64 +: 64]});
    exp_wr.push_back(b_err);
    addr = a; wr_req = 1'b1; wr_data = line; wr_strb = strb;
    tick();
    chk("wr_awvalid_first", 64'(bus.awvalid), 64'd1);
    chk("wr_wvalid_first",  64'(bus.wvalid),  64'd1);
    chk("wr_no_arvalid",    64'(bus.arvalid), 64'd0);
    bus.wready  = 1'b1;
    bus.awready = (aw_delay == 0);
    for (int i = 0; i < nb; i++) begin
      tick();
      bus.awready = 1'b0;
    end
    bus.wready = 1'b0;
    if (aw_delay > 0) begin
      for (int i = 0; i < aw_delay; i++) begin
        chk("b_wait_bready", 64'(bus.bready),  64'd0);
        chk("b_wait_wvalid", 64'(bus.wvalid),  64'd0);
        chk("b_wait_awvalid", 64'(bus.awvalid), 64'd1);
        tick();
      end
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
    end
    chk("b_enter_bready", 64'(bus.bready), 64'd1);
    bus.bvalid = 1'b1;
    bus.bresp  = b_err ? 2'b10 : 2'b00;
    tick();
    wr_req = 1'b0;
    slave_idle();
    chk("b_exit_bready", 64'(bus.bready), 64'd0);
  endtask

  logic [511:0] line_a, line_b;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; addr = 32'd0; rd_req = 1'b0; wr_req = 1'b0; wr_data = 512'd0; wr_strb = 8'd0;
    slave_idle();
    for (int i = 0; i < 8; i++) begin
      line_a[i*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(i + 1);
      line_b[i*64 +: 64] = 64'hC0DE_0000_0000_0000 + 64'(i * 16);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_arvalid",  64'(bus.arvalid), 64'd0);
    chk("reset_awvalid",  64'(bus.awvalid), 64'd0);
    chk("reset_wvalid",   64'(bus.wvalid),  64'd0);
    chk("reset_rready",   64'(bus.rready),  64'd0);
    chk("reset_bready",   64'(bus.bready),  64'd0);
    chk("reset_rd_ready", 64'(rd_ready),    64'd0);
    chk("reset_wr_ready", 64'(wr_ready),    64'd0);
    rst_n = 1'b1;
    tick();

    do_read(32'h8000_0040, 8, -1, 99, 64'hA000_0000_0000_0000);
    do_write(32'h1000_0000, {448'd0, 64'h0000_0000_DEAD_BEEF}, 8'h0F, 1, 0, 1'b0);
    do_write(32'h8000_1000, line_a, 8'h00, 8, 3, 1'b1);
    rd_req = 1'b1;
    do_write(32'h8000_2000, line_b, 8'h33, 8, 0, 1'b0);
    do_read(32'h8000_0080, 8, -1, 99, 64'hB000_0000_0000_0007);
    do_read(32'h8000_0100, 8, 3, 99, 64'h5555_0000_0000_0000);
    do_read(32'h0000_2004, 1, -1, 99, 64'h0123_4567_89AB_CDEF);
    do_read(32'h8000_0200, 8, -1, 4, 64'hE000_0000_0000_0000);
    do_read(32'h8000_0240, 8, -1, 99, 64'hF000_0000_0000_0000);
    tick();

    chk("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
    chk("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
    chk("w_queue_empty",  64'(exp_w.size()),  64'd0);
    chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
